// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: ALU op codes, FSM encoding, latched request
// record and the EXEC timer load helper.
package alu_arbiter_pkg;

  localparam int DataWidth = 32;
  localparam int OpWidth   = 5;
  localparam int CntWidth  = 4;

  localparam logic [OpWidth-1:0] ALUAnd       = 5'd0;
  localparam logic [OpWidth-1:0] ALUOr        = 5'd1;
  localparam logic [OpWidth-1:0] ALUXor       = 5'd2;
  localparam logic [OpWidth-1:0] ALUSignPlus  = 5'd3;
  localparam logic [OpWidth-1:0] ALUSignMinus = 5'd4;
  localparam logic [OpWidth-1:0] ALUEqual     = 5'd5;
  localparam logic [OpWidth-1:0] ALUNotEqual  = 5'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arbState_e;

  typedef struct packed {
    logic [OpWidth-1:0]   op;
    logic [DataWidth-1:0] a;
    logic [DataWidth-1:0] b;
  } aluReq_t;

  // The EXEC timer counts down to zero, so it starts one below the cycle count.
  function automatic logic [CntWidth-1:0] execLoad(input int cycles);
    return CntWidth'(cycles - 1);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: grants are combinational, the last-grant pointer
// is the only state and points at port 1 out of reset so port 0 wins first.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic lastGrant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        grant0 = lastGrant;
        grant1 = !lastGrant;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant <= 1'b1;
    end else if (grant0) begin
      lastGrant <= 1'b0;
    end else if (grant1) begin
      lastGrant <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: round-robin grant, fixed
// settle time, then a held response to the owning requester.
//
// state | meaning
// IDLE  | arbitrating; reqN_ready follows the grant
// EXEC  | ALU driven from latched operands, down-counter running
// RESP  | result held on the owner's rsp port until rspN_ready
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OpWidth-1:0]   req0_op,
  input  logic [DataWidth-1:0] req0_a,
  input  logic [DataWidth-1:0] req0_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [DataWidth-1:0] rsp0_out,
  output logic                 rsp0_zero,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OpWidth-1:0]   req1_op,
  input  logic [DataWidth-1:0] req1_a,
  input  logic [DataWidth-1:0] req1_b,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [DataWidth-1:0] rsp1_out,
  output logic                 rsp1_zero,
  output logic [OpWidth-1:0]   alu_op,
  output logic [DataWidth-1:0] alu_a,
  output logic [DataWidth-1:0] alu_b,
  input  logic [DataWidth-1:0] alu_out,
  input  logic                 alu_zero,
  output logic                 busy
);

  arbState_e           state;
  logic                ownerId;
  aluReq_t             latched;
  logic [CntWidth-1:0] cnt;
  logic                grant0;
  logic                grant1;
  logic                rspFire;

  // Gated with rst so no ready can leak out while reset is held.
  rr_arbiter2 uArb (
    .clk    (clk),
    .rst    (rst),
    .enable ((state == IDLE) && !rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_op = latched.op;
  assign alu_a  = latched.a;
  assign alu_b  = latched.b;

  assign rspFire = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ownerId    <= 1'b0;
      latched    <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_out   <= '0;
      rsp0_zero  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_out   <= '0;
      rsp1_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            ownerId <= grant1;
            latched <= grant1 ? aluReq_t'{req1_op, req1_a, req1_b}
                              : aluReq_t'{req0_op, req0_a, req0_b};
            cnt     <= execLoad(EXEC_CYCLES);
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state <= RESP;
            if (ownerId) begin
              rsp1_valid <= 1'b1;
              rsp1_out   <= alu_out;
              rsp1_zero  <= alu_zero;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_out   <= alu_out;
              rsp0_zero  <= alu_zero;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // Results are cleared on handshake so idle rsp ports read as zero.
          if (rspFire) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_out   <= '0;
            rsp0_zero  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_out   <= '0;
            rsp1_zero  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table through the EXEC_CYCLES=1 instance,
// hand sequences for contention, backpressure and reset, and an EXEC_CYCLES=3 instance.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic req0Valid = 1'b0, req1Valid = 1'b0, rsp0Ready = 1'b0, rsp1Ready = 1'b0;
  logic [4:0] req0Op = '0, req1Op = '0;
  logic [31:0] req0A = '0, req0B = '0, req1A = '0, req1B = '0;
  logic req0Ready, req1Ready, rsp0Valid, rsp1Valid, rsp0Zero, rsp1Zero, busy, aluZero;
  logic [31:0] rsp0Out, rsp1Out, aluA, aluB, aluOut;
  logic [4:0] aluOp;

  logic bRst = 1'b1;
  logic bReq0Valid = 1'b0, bReq1Valid = 1'b0, bRsp0Ready = 1'b0, bRsp1Ready = 1'b0;
  logic [4:0] bReq0Op = '0, bReq1Op = '0;
  logic [31:0] bReq0A = '0, bReq0B = '0, bReq1A = '0, bReq1B = '0;
  logic bReq0Ready, bReq1Ready, bRsp0Valid, bRsp1Valid, bRsp0Zero, bRsp1Zero, bBusy, bAluZero;
  logic [31:0] bRsp0Out, bRsp1Out, bAluA, bAluB, bAluOut;
  logic [4:0] bAluOp;

  int nVec = 0;
  int nFail = 0;

  function automatic logic [32:0] aluModel(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALUAnd:       r = a & b;
      ALUOr:        r = a | b;
      ALUSignPlus:  r = a + b;
      ALUSignMinus: r = a - b;
      ALUEqual:     return {a == b, 32'd0};
      ALUNotEqual:  return {a != b, 32'd0};
      default:      r = a ^ b;
    endcase
    return {r == 32'd0, r};
  endfunction

  assign {aluZero, aluOut}   = aluModel(aluOp, aluA, aluB);
  assign {bAluZero, bAluOut} = aluModel(bAluOp, bAluA, bAluB);

  alu_arbiter #(.EXEC_CYCLES(1)) uDut (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_op(req0Op), .req0_a(req0A), .req0_b(req0B),
    .rsp0_valid(rsp0Valid), .rsp0_ready(rsp0Ready), .rsp0_out(rsp0Out), .rsp0_zero(rsp0Zero),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_op(req1Op), .req1_a(req1A), .req1_b(req1B),
    .rsp1_valid(rsp1Valid), .rsp1_ready(rsp1Ready), .rsp1_out(rsp1Out), .rsp1_zero(rsp1Zero),
    .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB), .alu_out(aluOut), .alu_zero(aluZero),
    .busy(busy)
  );

  alu_arbiter #(.EXEC_CYCLES(3)) uDut3 (
    .clk(clk), .rst(bRst),
    .req0_valid(bReq0Valid), .req0_ready(bReq0Ready), .req0_op(bReq0Op), .req0_a(bReq0A), .req0_b(bReq0B),
    .rsp0_valid(bRsp0Valid), .rsp0_ready(bRsp0Ready), .rsp0_out(bRsp0Out), .rsp0_zero(bRsp0Zero),
    .req1_valid(bReq1Valid), .req1_ready(bReq1Ready), .req1_op(bReq1Op), .req1_a(bReq1A), .req1_b(bReq1B),
    .rsp1_valid(bRsp1Valid), .rsp1_ready(bRsp1Ready), .rsp1_out(bRsp1Out), .rsp1_zero(bRsp1Zero),
    .alu_op(bAluOp), .alu_a(bAluA), .alu_b(bAluB), .alu_out(bAluOut), .alu_zero(bAluZero),
    .busy(bBusy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ALU operands must hold the granted request from grant until IDLE re-entry.
  logic trk = 1'b0;
  logic [4:0] expOp = '0;
  logic [31:0] expA = '0, expB = '0;
  always @(negedge clk) begin
    if (rst) begin
      trk <= 1'b0;
    end else begin
      check("ready exclusive", 32'(req0Ready & req1Ready), 32'd0);
      if (trk && busy) begin
        check("alu_op stable", 32'(aluOp), 32'(expOp));
        check("alu_a stable", aluA, expA);
        check("alu_b stable", aluB, expB);
      end
      if (req0Ready) begin
        trk <= 1'b1; expOp <= req0Op; expA <= req0A; expB <= req0B;
      end else if (req1Ready) begin
        trk <= 1'b1; expOp <= req1Op; expA <= req1A; expB <= req1B;
      end else if (!busy) begin
        trk <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        port;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expOut;
    logic        expZero;
  } vec_t;

  vec_t vecs[9];

  task automatic waitGrant(input logic port, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = port ? req1Ready : req0Ready;
    end
    check("grant timeout", 32'(got), 32'd1);
  endtask

  task automatic waitRsp(input logic port, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = port ? rsp1Valid : rsp0Valid;
    end
    check("rsp timeout", 32'(got), 32'd1);
  endtask

  task automatic runOp(input vec_t v, input string tag, input int expLat);
    bit got;
    int lat;
    @(posedge clk); #1;
    if (v.port) begin req1Valid = 1; req1Op = v.op; req1A = v.a; req1B = v.b; end
    else        begin req0Valid = 1; req0Op = v.op; req0A = v.a; req0B = v.b; end
    waitGrant(v.port, got);
    @(posedge clk); #1;
    req0Valid = 0; req1Valid = 0;
    lat = 1; got = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk);
      got = v.port ? rsp1Valid : rsp0Valid;
      if (!got) lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'(expLat));
    check($sformatf("%s out", tag), v.port ? rsp1Out : rsp0Out, v.expOut);
    check($sformatf("%s zero", tag), 32'(v.port ? rsp1Zero : rsp0Zero), 32'(v.expZero));
    check($sformatf("%s other valid", tag), 32'(v.port ? rsp0Valid : rsp1Valid), 32'd0);
    if (v.port) rsp1Ready = 1; else rsp0Ready = 1;
    @(posedge clk); #1;
    rsp0Ready = 0; rsp1Ready = 0;
    @(negedge clk);
    check($sformatf("%s valid cleared", tag), 32'(v.port ? rsp1Valid : rsp0Valid), 32'd0);
    check($sformatf("%s out cleared", tag), v.port ? rsp1Out : rsp0Out, 32'd0);
    check($sformatf("%s idle", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int lat;
    vecs[0] = '{1'b0, ALUSignPlus, 32'd5, 32'd7, 32'd12, 1'b0};
    vecs[1] = '{1'b1, ALUSignPlus, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1};
    vecs[2] = '{1'b0, ALUAnd, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0};
    vecs[3] = '{1'b1, ALUOr, 32'hFF00, 32'h0FF0, 32'hFFF0, 1'b0};
    vecs[4] = '{1'b0, ALUEqual, 32'h1234, 32'h1234, 32'd0, 1'b1};
    vecs[5] = '{1'b1, ALUNotEqual, 32'h1234, 32'h1234, 32'd0, 1'b0};
    vecs[6] = '{1'b0, ALUEqual, 32'd1, 32'd2, 32'd0, 1'b0};
    vecs[7] = '{1'b1, 5'd31, 32'h10, 32'h01, 32'h11, 1'b0};
    vecs[8] = '{1'b0, ALUAnd, 32'hF0, 32'h0F, 32'd0, 1'b1};

    // Reset: every output low, and requests raised during reset see no ready.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp0_valid", 32'(rsp0Valid), 32'd0);
    check("reset rsp1_valid", 32'(rsp1Valid), 32'd0);
    check("reset rsp0_out", rsp0Out, 32'd0);
    check("reset rsp1_out", rsp1Out, 32'd0);
    check("reset alu_op", 32'(aluOp), 32'd0);
    check("reset alu_a", aluA, 32'd0);
    check("reset alu_b", aluB, 32'd0);
    req0Valid = 1; req0Op = ALUAnd; req0A = 32'hFF00; req0B = 32'h0FF0;
    req1Valid = 1; req1Op = ALUOr;  req1A = 32'hFF00; req1B = 32'h0FF0;
    #1;
    check("reset req0_ready", 32'(req0Ready), 32'd0);
    check("reset req1_ready", 32'(req1Ready), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Contention from reset: port 0 first, then strict alternation.
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        got = rsp0Valid | rsp1Valid;
      end
      check($sformatf("cont%0d timeout", k), 32'(got), 32'd1);
      check($sformatf("cont%0d port", k), 32'(rsp1Valid), 32'(k % 2));
      check($sformatf("cont%0d both", k), 32'(rsp0Valid & rsp1Valid), 32'd0);
      check($sformatf("cont%0d out", k), rsp1Valid ? rsp1Out : rsp0Out,
            (k % 2) ? 32'hFFF0 : 32'h0F00);
      if (rsp1Valid) rsp1Ready = 1; else rsp0Ready = 1;
      @(posedge clk); #1;
      rsp0Ready = 0; rsp1Ready = 0;
    end
    req0Valid = 0; req1Valid = 0;
    @(negedge clk);
    check("cont drained", 32'(busy), 32'd0);

    // Backpressure on port 1 while port 0 waits.
    @(posedge clk); #1;
    req1Valid = 1; req1Op = ALUSignPlus; req1A = 32'd1; req1B = 32'd2;
    waitGrant(1'b1, got);
    @(posedge clk); #1;
    req1Valid = 0;
    req0Valid = 1; req0Op = ALUSignPlus; req0A = 32'd10; req0B = 32'd20;
    waitRsp(1'b1, got);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp%0d rsp1_valid", i), 32'(rsp1Valid), 32'd1);
      check($sformatf("bp%0d rsp1_out", i), rsp1Out, 32'd3);
      check($sformatf("bp%0d busy", i), 32'(busy), 32'd1);
      check($sformatf("bp%0d req0_ready", i), 32'(req0Ready), 32'd0);
      @(negedge clk);
    end
    rsp1Ready = 1;
    @(posedge clk); #1;
    rsp1Ready = 0;
    @(negedge clk);
    check("bp req0 granted after", 32'(req0Ready), 32'd1);
    @(posedge clk); #1;
    req0Valid = 0;
    waitRsp(1'b0, got);
    check("bp req0 out", rsp0Out, 32'd30);
    rsp0Ready = 1;
    @(posedge clk); #1;
    rsp0Ready = 0;

    // rsp0_ready held high before the result exists must not end the operation.
    rsp0Ready = 1;
    req0Valid = 1; req0Op = ALUSignPlus; req0A = 32'd2; req0B = 32'd2;
    waitGrant(1'b0, got);
    @(posedge clk); #1;
    req0Valid = 0;
    waitRsp(1'b0, got);
    check("early ready out", rsp0Out, 32'd4);
    @(negedge clk);
    check("early ready consumed", 32'(rsp0Valid), 32'd0);
    rsp0Ready = 0;

    for (int i = 0; i < 9; i++) runOp(vecs[i], $sformatf("vec%0d", i), 2);

    // EXEC_CYCLES=3 instance: latency, then reset in the second EXEC cycle.
    @(posedge clk); #1;
    bRst = 0;
    bReq0Valid = 1; bReq0Op = ALUSignPlus; bReq0A = 32'd5; bReq0B = 32'd7;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); got = bReq0Ready; end
    check("x3 grant", 32'(got), 32'd1);
    @(posedge clk); #1;
    bReq0Valid = 0;
    lat = 1; got = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk);
      got = bRsp0Valid;
      if (!got) lat++;
    end
    check("x3 latency", 32'(lat), 32'd4);
    check("x3 out", bRsp0Out, 32'd12);
    bRsp0Ready = 1;
    @(posedge clk); #1;
    bRsp0Ready = 0;

    bReq0Valid = 1; bReq0Op = ALUSignPlus; bReq0A = 32'd1; bReq0B = 32'd1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); got = bReq0Ready; end
    check("x3 grant2", 32'(got), 32'd1);
    @(posedge clk); #1;
    bReq0Valid = 0;
    @(posedge clk); #1;
    bRst = 1;
    @(negedge clk);
    check("x3 busy in exec", 32'(bBusy), 32'd1);
    @(posedge clk); #1;
    bRst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("x3 dropped%0d", i), 32'(bRsp0Valid | bRsp1Valid | bBusy), 32'd0);
    end
    check("x3 alu_a cleared", bAluA, 32'd0);
    @(posedge clk); #1;
    bReq0Valid = 1; bReq0Op = ALUAnd; bReq0A = 32'd3; bReq0B = 32'd1;
    bReq1Valid = 1; bReq1Op = ALUOr;  bReq1A = 32'd3; bReq1B = 32'd1;
    @(negedge clk);
    check("x3 post-reset req0_ready", 32'(bReq0Ready), 32'd1);
    check("x3 post-reset req1_ready", 32'(bReq1Ready), 32'd0);
    @(posedge clk); #1;
    bReq0Valid = 0; bReq1Valid = 0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); got = bRsp0Valid; end
    check("x3 post-reset rsp", 32'(got), 32'd1);
    check("x3 post-reset out", bRsp0Out, 32'd1);
    bRsp0Ready = 1;
    @(posedge clk); #1;
    bRsp0Ready = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
